// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver and its history table.
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_RESET           = 2'b01;
  localparam int   BHT_ENTRIES_DEFAULT = 16;

  // Saturating 2-bit counter step.
  function automatic cnt_t cnt_next(input cnt_t c, input logic tk);
    if (tk) return (c == 2'b11) ? c : cnt_t'(c + 2'b01);
    else    return (c == 2'b00) ? c : cnt_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating predictors: combinational read, synchronous update.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = BHT_ENTRIES_DEFAULT,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cnt_t             rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  cnt_t cnt_q [ENTRIES];

  // Read sees the pre-update value when an update hits the same index.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branches/jumps one cycle after acceptance and trains the BHT
// when a conditional-branch result is consumed.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pred_next_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic [31:0] link_addr,
  output logic        mispredict,
  output logic        illegal,
  input  logic        flush,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             xfer;
  logic             eq, lt, ltu;
  logic             taken_c, illegal_c, sel_br_c;
  logic [31:0]      target_c, pc4_c, next_c;

  logic             out_valid_q, out_valid_d;
  logic             taken_q, mispredict_q, illegal_q, br_q;
  logic [31:0]      next_pc_q, link_q;
  logic [IDX_W-1:0] idx_q;
  cnt_t             rd_cnt;
  logic             upd_en;

  assign in_ready = !out_valid_q | out_ready;
  assign xfer     = in_valid & in_ready & !flush;

  assign eq  = (rs1_data == rs2_data);
  assign lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu = (rs1_data < rs2_data);
  assign pc4_c = pc + 32'd4;

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    sel_br_c  = 1'b0;
    target_c  = pc + imm;
    if (is_jalr) begin
      taken_c  = 1'b1;
      target_c = (rs1_data + imm) & 32'hFFFF_FFFE;
    end else if (is_jal) begin
      taken_c = 1'b1;
    end else if (is_branch) begin
      sel_br_c = 1'b1;
      case (br_funct3_e'(funct3))
        F3_BEQ:  taken_c = eq;
        F3_BNE:  taken_c = !eq;
        F3_BLT:  taken_c = lt;
        F3_BGE:  taken_c = !lt;
        F3_BLTU: taken_c = ltu;
        F3_BGEU: taken_c = !ltu;
        default: illegal_c = 1'b1;
      endcase
    end
    next_c = taken_c ? target_c : pc4_c;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (xfer)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      br_q         <= 1'b0;
      next_pc_q    <= '0;
      link_q       <= '0;
      idx_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (xfer) begin
        taken_q      <= taken_c;
        mispredict_q <= (next_c != pred_next_pc);
        illegal_q    <= illegal_c;
        br_q         <= sel_br_c;
        next_pc_q    <= next_c;
        link_q       <= pc4_c;
        idx_q        <= pc[IDX_W+1:2];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign next_pc    = next_pc_q;
  assign link_addr  = link_q;
  assign mispredict = mispredict_q;
  assign illegal    = illegal_q;

  // Train only on a consumed, legal conditional branch that is not being flushed.
  assign upd_en = out_valid_q & out_ready & br_q & !illegal_q & !flush;

  branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (fetch_pc[IDX_W+1:2]),
    .rd_cnt_o   (rd_cnt),
    .upd_en_i   (upd_en),
    .upd_idx_i  (idx_q),
    .upd_taken_i(taken_q)
  );

  assign pred_taken = rd_cnt[1];

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0], rd_cnt[0]};

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: vector table plus handshake/BHT/flush/reset sequences.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1_data, rs2_data, imm, pred_next_pc;
  logic        out_valid, out_ready;
  logic        taken;
  logic [31:0] next_pc, link_addr;
  logic        mispredict, illegal;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_taken;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolver #(.BHT_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pred_next_pc(pred_next_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .next_pc(next_pc), .link_addr(link_addr),
    .mispredict(mispredict), .illegal(illegal),
    .flush(flush), .fetch_pc(fetch_pc), .pred_taken(pred_taken)
  );

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm, pred;
    logic        e_tk;
    logic [31:0] e_npc, e_link;
    logic        e_mis, e_ill;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] pr);
    is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
    pc = p; rs1_data = a; rs2_data = b; imm = im; pred_next_pc = pr;
  endtask

  // Present one request for one edge; returns 1 ns after that edge.
  task automatic send(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] pr);
    drive(br, jal, jalr, f3, p, a, b, im, pr);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"},  {31'd0, out_valid},  32'd0);
    chk({tag, " taken"},      {31'd0, taken},      32'd0);
    chk({tag, " mispredict"}, {31'd0, mispredict}, 32'd0);
    chk({tag, " illegal"},    {31'd0, illegal},    32'd0);
    chk({tag, " next_pc"},    next_pc,             32'd0);
    chk({tag, " link_addr"},  link_addr,           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //            br jal jalr f3    pc             rs1            rs2            imm            pred           tk npc            link           mis ill
    vecs[0]  = '{1, 0, 0, 3'd4, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0020, 32'h0000_0104, 1, 32'h0000_0120, 32'h0000_0104, 1, 0};
    vecs[1]  = '{1, 0, 0, 3'd6, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0020, 32'h0000_0104, 0, 32'h0000_0104, 32'h0000_0104, 0, 0};
    vecs[2]  = '{0, 0, 1, 3'd0, 32'h0000_0200, 32'h0000_1003, 32'h0000_0000, 32'h0000_0000, 32'h0000_0204, 1, 32'h0000_1002, 32'h0000_0204, 1, 0};
    vecs[3]  = '{1, 0, 0, 3'd0, 32'h0000_0300, 32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFF0, 32'h0000_02F0, 1, 32'h0000_02F0, 32'h0000_0304, 0, 0};
    vecs[4]  = '{1, 0, 0, 3'd1, 32'h0000_0300, 32'h0000_0005, 32'h0000_0005, 32'h0000_0008, 32'h0000_0308, 0, 32'h0000_0304, 32'h0000_0304, 1, 0};
    vecs[5]  = '{1, 0, 0, 3'd5, 32'h0000_0400, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0040, 32'h0000_0404, 1, 32'h0000_0440, 32'h0000_0404, 1, 0};
    vecs[6]  = '{1, 0, 0, 3'd7, 32'h0000_0400, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0040, 32'h0000_0404, 0, 32'h0000_0404, 32'h0000_0404, 0, 0};
    vecs[7]  = '{0, 1, 0, 3'd0, 32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h0000_0600, 1, 32'h0000_0600, 32'h0000_0504, 0, 0};
    vecs[8]  = '{1, 0, 0, 3'd2, 32'h0000_0600, 32'h0000_0009, 32'h0000_0009, 32'h0000_0010, 32'h0000_0604, 0, 32'h0000_0604, 32'h0000_0604, 0, 1};
    vecs[9]  = '{1, 0, 0, 3'd3, 32'h0000_0610, 32'h0000_0009, 32'h0000_0001, 32'h0000_0010, 32'h0000_0700, 0, 32'h0000_0614, 32'h0000_0614, 1, 1};
    vecs[10] = '{0, 0, 0, 3'd0, 32'h0000_0700, 32'h0000_0001, 32'h0000_0001, 32'h0000_0040, 32'h0000_0704, 0, 32'h0000_0704, 32'h0000_0704, 0, 0};
    vecs[11] = '{1, 1, 1, 3'd1, 32'h0000_0800, 32'h0000_2000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0804, 1, 32'h0000_2004, 32'h0000_0804, 1, 0};
    vecs[12] = '{1, 1, 0, 3'd0, 32'h0000_0900, 32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h0000_0910, 1, 32'h0000_0910, 32'h0000_0904, 0, 0};
    vecs[13] = '{0, 1, 0, 3'd0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 32'h0000_0000, 1, 32'h0000_0004, 32'h0000_0000, 1, 0};
    vecs[14] = '{0, 0, 1, 3'd0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0002, 32'h0000_0014, 1, 32'h0000_0000, 32'h0000_0014, 1, 0};
    vecs[15] = '{1, 0, 0, 3'd4, 32'h0000_0020, 32'h0000_0007, 32'h0000_0007, 32'h0000_0040, 32'h0000_0024, 0, 32'h0000_0024, 32'h0000_0024, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    fetch_pc = 32'h0000_0040;
    drive(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #23;
    check_reset_outputs("reset");
    chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset in_ready",   {31'd0, in_ready},   32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table, back-to-back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3, vecs[i].pc,
           vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pred);
      chk($sformatf("v%0d out_valid", i),  {31'd0, out_valid},  32'd1);
      chk($sformatf("v%0d taken", i),      {31'd0, taken},      {31'd0, vecs[i].e_tk});
      chk($sformatf("v%0d next_pc", i),    next_pc,             vecs[i].e_npc);
      chk($sformatf("v%0d link_addr", i),  link_addr,           vecs[i].e_link);
      chk($sformatf("v%0d mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d illegal", i),    {31'd0, illegal},    {31'd0, vecs[i].e_ill});
    end
    idle();
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: result A held for 3 cycles while B waits.
    out_ready = 1'b0;
    send(0, 1, 0, 3'd0, 32'h0000_0A00, 32'd0, 32'd0, 32'h0000_0040, 32'h0000_0A04);
    chk("stall A valid", {31'd0, out_valid}, 32'd1);
    drive(1, 0, 0, 3'd0, 32'h0000_0B00, 32'd0, 32'd0, 32'h0000_0010, 32'h0000_0B10);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d out_valid", c),  {31'd0, out_valid},  32'd1);
      chk($sformatf("stall%0d next_pc", c),    next_pc,             32'h0000_0A40);
      chk($sformatf("stall%0d link_addr", c),  link_addr,           32'h0000_0A04);
      chk($sformatf("stall%0d taken", c),      {31'd0, taken},      32'd1);
      chk($sformatf("stall%0d mispredict", c), {31'd0, mispredict}, 32'd1);
      chk($sformatf("stall%0d in_ready", c),   {31'd0, in_ready},   32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("B out_valid",  {31'd0, out_valid},  32'd1);
    chk("B next_pc",    next_pc,             32'h0000_0B10);
    chk("B link_addr",  link_addr,           32'h0000_0B04);
    chk("B mispredict", {31'd0, mispredict}, 32'd0);
    idle();
    chk("B consumed out_valid", {31'd0, out_valid}, 32'd0);

    // Clean BHT, then train index of 0x40.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    idle();
    chk("bht init pred", {31'd0, pred_taken}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd3, 32'h0000_0008, 32'h0000_0044);
      chk($sformatf("beq%0d taken", k), {31'd0, taken}, 32'd1);
      idle();
      chk($sformatf("beq%0d pred", k), {31'd0, pred_taken}, 32'd1);
    end
    send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd4, 32'h0000_0008, 32'h0000_0044);
    idle();
    chk("nt1 pred (11->10)", {31'd0, pred_taken}, 32'd1);

    send(1, 0, 0, 3'd2, 32'h0000_0040, 32'd3, 32'd4, 32'h0000_0008, 32'h0000_0044);
    chk("illegal flag", {31'd0, illegal}, 32'd1);
    chk("illegal taken", {31'd0, taken}, 32'd0);
    idle();
    chk("illegal no bht change", {31'd0, pred_taken}, 32'd1);

    // Flush a held not-taken result while a new request is offered.
    out_ready = 1'b0;
    send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd4, 32'h0000_0008, 32'h0000_0044);
    chk("pre-flush valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; flush = 1'b1;
    drive(0, 1, 0, 3'd0, 32'h0000_0C00, 32'd0, 32'd0, 32'h0000_0010, 32'h0000_0C04);
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    idle();
    chk("flush dropped xfer", {31'd0, out_valid}, 32'd0);
    chk("flush no bht update", {31'd0, pred_taken}, 32'd1);

    send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd4, 32'h0000_0008, 32'h0000_0044);
    idle();
    chk("nt2 pred (10->01)", {31'd0, pred_taken}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd3, 32'h0000_0008, 32'h0000_0044);
      idle();
    end
    chk("retrain pred", {31'd0, pred_taken}, 32'd1);

    // Reset in the middle of a held result.
    out_ready = 1'b0;
    send(0, 1, 0, 3'd0, 32'h0000_0D00, 32'd0, 32'd0, 32'h0000_0020, 32'h0000_0D04);
    chk("pre-reset valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset pred", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1, 0, 0, 3'd0, 32'h0000_0040, 32'd3, 32'd3, 32'h0000_0008, 32'h0000_0044);
    chk("first accept after reset", {31'd0, out_valid}, 32'd1);
    chk("first accept next_pc", next_pc, 32'h0000_0048);
    chk("same-cycle lookup pre-update", {31'd0, pred_taken}, 32'd0);
    idle();
    chk("post-reset counter 01->10", {31'd0, pred_taken}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
